// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined ARMv8 register-shift unit.
// Holds the shift-type encodings and the helpers that work out which
// shift-amount bits each pipeline stage is responsible for.
package shifter_pkg;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_op_e;

  // Amount bits are dealt out in contiguous groups from the LSB upward.
  function automatic int group_size(input int shamt_w, input int stages);
    return (shamt_w + stages - 1) / stages;
  endfunction

  // Lowest amount bit handled by stage k. It is clamped to shamt_w so that
  // trailing stages with nothing left to do come out empty (hi = lo - 1).
  function automatic int stage_lo(input int k, input int shamt_w, input int stages);
    int lo;
    lo = k * group_size(shamt_w, stages);
    return (lo > shamt_w) ? shamt_w : lo;
  endfunction

  // Highest amount bit handled by stage k.
  function automatic int stage_hi(input int k, input int shamt_w, input int stages);
    int hi;
    hi = (k + 1) * group_size(shamt_w, stages) - 1;
    return (hi > shamt_w - 1) ? shamt_w - 1 : hi;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One register stage of the logarithmic shifter.
// Applies the power-of-two shifts selected by amount bits LO_BIT..HI_BIT
// and registers the result together with the amount, op and sf that travel
// alongside it. A stage with HI_BIT < LO_BIT is a pure register.
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   in_valid / in_ready     upstream handshake (in_ready = empty or draining)
//   in_data, in_shamt,
//   in_op, in_sf            beat entering this stage
//   out_valid / out_ready   downstream handshake
//   out_data, out_shamt,
//   out_op, out_sf          registered beat leaving this stage
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int LO_BIT = 0,
  parameter int HI_BIT = 0,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  shift_op_e          in_op,
  input  logic               in_sf,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SHAMT_W-1:0] out_shamt,
  output shift_op_e          out_op,
  output logic               out_sf
);

  localparam int NBITS = HI_BIT - LO_BIT + 1;

  // A single fixed-distance step of the selected shift type. ASR relies on
  // the MSB surviving earlier steps, which an arithmetic shift guarantees.
  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] d,
                                            input shift_op_e op, input int k);
    case (op)
      SH_LSL:  return d << k;
      SH_LSR:  return d >> k;
      SH_ASR:  return $signed(d) >>> k;
      default: return (d >> k) | (d << (WIDTH - k));
    endcase
  endfunction

  logic [WIDTH-1:0] chain [NBITS+1];

  assign chain[0] = in_data;

  // Cascade of conditional shifts, one per amount bit owned by this stage.
  for (genvar g = 0; g < NBITS; g++) begin : g_step
    assign chain[g+1] = in_shamt[LO_BIT+g] ? step(chain[g], in_op, 1 << (LO_BIT + g))
                                           : chain[g];
  end

  // The stage can take a new beat when it is empty or its beat leaves now.
  assign in_ready = !out_valid || out_ready;

  // Stage register: loads only on an accepted beat, otherwise holds so a
  // stalled result stays stable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_shamt <= '0;
      out_op    <= SH_LSL;
      out_sf    <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data  <= chain[NBITS];
        out_shamt <= in_shamt;
        out_op    <= in_op;
        out_sf    <= in_sf;
      end
    end
  end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined ARMv8 register-shift unit (LSL/LSR/ASR/ROR, X and W forms).
// Latency equals STAGES; one beat per cycle with valid/ready flow control.
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   in_valid / in_ready     operand handshake
//   a, shamt, op, sf        operand, amount, shift type, 1 = X / 0 = W form
//   out_valid / out_ready   result handshake
//   s                       result (upper half zero for W form)
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         op,
  input  logic               sf,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   s
);

  localparam int HALF = WIDTH / 2;

  shift_op_e          op_e;
  logic [HALF-1:0]    a_lo;
  logic [WIDTH-1:0]   fmt_data;
  logic [SHAMT_W-1:0] fmt_shamt;

  logic               valid_c [STAGES+1];
  logic               ready_c [STAGES+1];
  logic [WIDTH-1:0]   data_c  [STAGES+1];
  logic [SHAMT_W-1:0] shamt_c [STAGES+1];
  shift_op_e          op_c    [STAGES+1];
  logic               sf_c    [STAGES+1];

  assign op_e = shift_op_e'(op);
  assign a_lo = a[HALF-1:0];

  // W-form pre-format: place the low half so that a full-width shift leaves
  // the correct W result in the low half. Rotates see two copies of the low
  // half, so a full-width rotate by less than HALF is a correct W rotate.
  // The amount loses its top bit in W form, giving mod-HALF semantics.
  always_comb begin
    fmt_data  = a;
    fmt_shamt = shamt;
    if (!sf) begin
      fmt_shamt[SHAMT_W-1] = 1'b0;
      case (op_e)
        SH_ASR:  fmt_data = {{HALF{a_lo[HALF-1]}}, a_lo};
        SH_ROR:  fmt_data = {a_lo, a_lo};
        default: fmt_data = {{HALF{1'b0}}, a_lo};
      endcase
    end
  end

  assign valid_c[0] = in_valid;
  assign data_c[0]  = fmt_data;
  assign shamt_c[0] = fmt_shamt;
  assign op_c[0]    = op_e;
  assign sf_c[0]    = sf;

  assign ready_c[STAGES] = out_ready;
  assign in_ready        = ready_c[0];

  // Ready ripples backward combinationally through the chain of stages.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    shift_stage #(
      .WIDTH  (WIDTH),
      .LO_BIT (stage_lo(k, SHAMT_W, STAGES)),
      .HI_BIT (stage_hi(k, SHAMT_W, STAGES))
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (valid_c[k]),
      .in_ready  (ready_c[k]),
      .in_data   (data_c[k]),
      .in_shamt  (shamt_c[k]),
      .in_op     (op_c[k]),
      .in_sf     (sf_c[k]),
      .out_valid (valid_c[k+1]),
      .out_ready (ready_c[k+1]),
      .out_data  (data_c[k+1]),
      .out_shamt (shamt_c[k+1]),
      .out_op    (op_c[k+1]),
      .out_sf    (sf_c[k+1])
    );
  end

  assign out_valid = valid_c[STAGES];

  // W results keep only the low half.
  assign s = sf_c[STAGES] ? data_c[STAGES] : {{HALF{1'b0}}, data_c[STAGES][HALF-1:0]};

  // Amount and op are not needed once the last stage has been applied.
  logic unused_tail;
  assign unused_tail = ^{shamt_c[STAGES], op_c[STAGES]};

endmodule
